// File: rtl/gate_checker.sv
// Exhaustive stimulus generator and response checker for an N-input combinational gate.
// Walks every input vector, holds it SETTLE cycles, and compares the sampled response against TRUTH.
module gate_checker #(
  parameter int                     N_IN   = 2,
  parameter logic [(2**N_IN)-1:0]   TRUTH  = 4'b1000,
  parameter int                     SETTLE = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail
);

  localparam int              N_VEC       = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(N_VEC - 1);
  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t          r_state, w_nextState;
  logic [N_IN-1:0] r_stim, w_nextStim;
  logic [3:0]      r_cnt, w_nextCnt;
  logic [N_IN:0]   r_errCount, w_nextErrCount;
  logic [N_IN-1:0] r_firstFail, w_nextFirstFail;
  logic            w_mismatch;

  // Four-state compare so an X/Z response in simulation counts as a failure.
  assign w_mismatch = (resp !== TRUTH[r_stim]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_stim      <= '0;
      r_cnt       <= '0;
      r_errCount  <= '0;
      r_firstFail <= '0;
    end else begin
      r_state     <= w_nextState;
      r_stim      <= w_nextStim;
      r_cnt       <= w_nextCnt;
      r_errCount  <= w_nextErrCount;
      r_firstFail <= w_nextFirstFail;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    w_nextStim      = r_stim;
    w_nextCnt       = r_cnt;
    w_nextErrCount  = r_errCount;
    w_nextFirstFail = r_firstFail;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_nextState     = WAIT;
          w_nextStim      = '0;
          w_nextCnt       = SETTLE_LOAD;
          w_nextErrCount  = '0;
          w_nextFirstFail = '0;
        end
      end
      WAIT: begin
        if (r_cnt != 4'd0) begin
          w_nextCnt = r_cnt - 4'd1;
        end else begin
          if (w_mismatch) begin
            w_nextErrCount = r_errCount + (N_IN+1)'(1);
            if (r_errCount == '0) begin
              w_nextFirstFail = r_stim;
            end
          end
          // Start is ignored here; the run always finishes after the last vector.
          if (r_stim == LAST_VEC) begin
            w_nextState = DONE;
          end else begin
            w_nextStim = r_stim + N_IN'(1);
            w_nextCnt  = SETTLE_LOAD;
          end
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign stim       = r_stim;
  assign busy       = (r_state == WAIT);
  assign done       = (r_state == DONE);
  assign pass       = done & (r_errCount == '0);
  assign err_count  = r_errCount;
  assign first_fail = r_firstFail;

endmodule

// File: tb/tb_gate_checker.sv
// Bench for gate_checker: a not2 loopback instance and an and2 instance with selectable good/faulty GUT models.
// Expected run results are queued at start and compared once done rises.
module tb_gate_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       startA, startN;
  logic [1:0] stimA;
  logic       respA, busyA, doneA, passA;
  logic [2:0] errA;
  logic [1:0] ffA;
  logic [0:0] stimN;
  logic       respN, busyN, doneN, passN;
  logic [1:0] errN;
  logic [0:0] ffN;
  int         respMode = 0;

  typedef struct packed {
    logic       pass;
    logic [2:0] err;
    logic [1:0] ff;
  } result_t;

  result_t sbQueue[$];
  int      checks = 0;
  int      errors = 0;

  always #5 clk = ~clk;

  // GUT models for the and2 instance: 0 = correct and2, 1 = or2 (wrong gate), 2 = stuck-at-0
  always_comb begin
    case (respMode)
      0:       respA = &stimA;
      1:       respA = |stimA;
      default: respA = 1'b0;
    endcase
  end

  assign respN = ~stimN[0];

  gate_checker #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(2)) dutAnd (
    .clk(clk), .rst(rst), .start(startA), .stim(stimA), .resp(respA),
    .busy(busyA), .done(doneA), .pass(passA), .err_count(errA), .first_fail(ffA)
  );

  gate_checker #(.N_IN(1), .TRUTH(2'b01), .SETTLE(1)) dutNot (
    .clk(clk), .rst(rst), .start(startN), .stim(stimN), .resp(respN),
    .busy(busyN), .done(doneN), .pass(passN), .err_count(errN), .first_fail(ffN)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic result_t modelRun(input int mode);
    logic [3:0] truth;
    logic       r;
    result_t    res;
    truth = 4'b1000;
    res   = '0;
    for (int v = 0; v < 4; v++) begin
      case (mode)
        0:       r = (v == 3);
        1:       r = (v != 0);
        default: r = 1'b0;
      endcase
      if (r !== truth[v]) begin
        if (res.err == 3'd0) res.ff = 2'(v);
        res.err = res.err + 3'd1;
      end
    end
    res.pass = (res.err == 3'd0);
    return res;
  endfunction

  // Full and2 run; extraPulse > 0 re-pulses start so it is sampled at edge E0+extraPulse.
  task automatic applyStimulus(input int mode, input int extraPulse);
    int      edges;
    result_t expRes;
    respMode = mode;
    @(negedge clk);
    startA = 1'b1;
    sbQueue.push_back(modelRun(mode));
    @(posedge clk);
    @(negedge clk);
    startA = 1'b0;
    edges  = 0;
    checkOutput("restart_done_low", doneA, 0);
    checkOutput("restart_err_clear", errA, 0);
    checkOutput("restart_ff_clear", ffA, 0);
    while (!doneA && edges < 40) begin
      checkOutput("seq_stim", stimA, edges / 2);
      checkOutput("seq_busy", busyA, 1);
      checkOutput("seq_pass_low", passA, 0);
      startA = (edges == extraPulse - 1);
      @(negedge clk);
      edges++;
    end
    startA = 1'b0;
    checkOutput("and2_latency", edges, 8);
    checkOutput("and2_done", doneA, 1);
    checkOutput("and2_busy_low", busyA, 0);
    checkOutput("and2_stim_hold", stimA, 3);
    if (sbQueue.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
    end else begin
      expRes = sbQueue.pop_front();
      checkOutput("and2_pass", passA, expRes.pass);
      checkOutput("and2_err_count", errA, expRes.err);
      checkOutput("and2_first_fail", ffA, expRes.ff);
    end
  endtask

  initial begin
    int edges;
    rst    = 1'b1;
    startA = 1'b0;
    startN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busyA, 0);
    checkOutput("rst_done", doneA, 0);
    checkOutput("rst_pass", passA, 0);
    checkOutput("rst_err", errA, 0);
    checkOutput("rst_ff", ffA, 0);
    checkOutput("rst_stim", stimA, 0);
    checkOutput("rst_not_done", doneN, 0);
    rst = 1'b0;

    $display("[TB] not2 loopback run");
    @(negedge clk);
    startN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    startN = 1'b0;
    edges  = 0;
    while (!doneN && edges < 20) begin
      checkOutput("not2_stim", stimN, edges);
      checkOutput("not2_busy", busyN, 1);
      @(negedge clk);
      edges++;
    end
    checkOutput("not2_latency", edges, 2);
    checkOutput("not2_busy_low", busyN, 0);
    checkOutput("not2_pass", passN, 1);
    checkOutput("not2_err", errN, 0);

    $display("[TB] and2 good run");
    applyStimulus(0, 0);
    $display("[TB] and2 faulty run (or2 behaviour)");
    applyStimulus(1, 0);
    $display("[TB] and2 good run with start re-pulsed mid-run");
    applyStimulus(0, 3);
    $display("[TB] and2 stuck-at-0 run");
    applyStimulus(2, 0);

    $display("[TB] asynchronous reset mid-run");
    respMode = 1;
    @(negedge clk);
    startA = 1'b1;
    @(posedge clk);
    @(negedge clk);
    startA = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("mid_busy", busyA, 1);
    checkOutput("mid_err", errA, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", busyA, 0);
    checkOutput("mid_rst_done", doneA, 0);
    checkOutput("mid_rst_pass", passA, 0);
    checkOutput("mid_rst_err", errA, 0);
    checkOutput("mid_rst_ff", ffA, 0);
    checkOutput("mid_rst_stim", stimA, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
# gate_checker

Synthesizable exhaustive stimulus generator and response checker for a combinational gate under test (GUT). It walks every input vector of an N-input gate, waits a programmable settle time, samples the gate's output and compares it against a truth table held as a parameter. It is the hardware counterpart of our per-gate benches: it lets any primitive (not2, and2, or2, xor2, mux2, …) be self-tested on silicon or in a gate-level sim with only a start pulse and a pass/fail readout.

## Interface
Parameters:
- N_IN, default 2: number of GUT inputs, 1..8; vector count N_VEC = 2**N_IN.
- TRUTH, default 4'b1000 (and2): N_VEC-bit expected output; bit i is the expected response to stimulus value i.
- SETTLE, default 2: cycles each vector is held before the response is sampled, 1..15.

Ports:
- clk  in  1  sole clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a full check.
- stim  out  N_IN  registered stimulus driven to the GUT inputs; stim[0] is the LSB of the vector index.
- resp  in  1  GUT output; treated as combinational from stim.
- busy  out  1  high while a check is running.
- done  out  1  high from run completion until the next accepted start or reset.
- pass  out  1  valid when done; 1 iff err_count == 0.
- err_count  out  N_IN+1  number of mismatching vectors in the last or current run, saturates never (max N_VEC fits).
- first_fail  out  N_IN  index of the first mismatching vector; valid when err_count != 0.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: start=1 → stim=0, settle counter=SETTLE-1, err_count=0, first_fail=0, done=0, → WAIT.
- WAIT: counter != 0 → decrement. counter == 0 → sample resp, compare with TRUTH[stim]:
  - mismatch: err_count+1; if err_count was 0, first_fail=stim.
  - stim == N_VEC-1 → DONE; else stim+1, counter=SETTLE-1, stay WAIT.
- DONE: done=1, stim holds last vector. start=1 → same actions as IDLE start (restart).
- start while in WAIT is ignored; the run is not restarted or extended.
- resp is compared against a known bit; resp X/Z in simulation counts as mismatch (use !== semantics in the compare, i.e. resp must equal TRUTH bit exactly).
- pass = done & (err_count == 0); pass is 0 whenever done is 0.
- busy = (state == WAIT).

## Timing
- Reset (async, immediate, mid-run included): state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0.
- start sampled at edge E0 → busy=1 and stim=0 visible after E0.
- Each vector held exactly SETTLE cycles; resp sampled at the last edge of that window, so GUT path must settle within SETTLE cycles.
- Last sample at edge E0 + N_VEC*SETTLE; done=1, busy=0 after that same edge. No idle gap between vectors.
- err_count/first_fail update at the sampling edge, visible the following cycle.
- Restart from DONE: done drops and stim=0 after the accepting edge; counters cleared in the same edge.

## Test plan
- not2 loopback: N_IN=1, TRUTH=2'b01, SETTLE=1, resp=~stim[0]; pulse start → busy for 2 cycles, done=1 at E0+2, pass=1, err_count=0.
- and2 good: N_IN=2, TRUTH=4'b1000, SETTLE=2, resp=&stim → stim sequence 0,0,1,1,2,2,3,3; done at E0+8, pass=1.
- and2 faulty (resp=|stim): → err_count=2, first_fail=1, pass=0, done=1.
- start pulsed again at E0+3 during run → ignored; done still at E0+8, results unchanged; then start in DONE → clean rerun, done at E1+8.
- rst asserted at E0+5 mid-run (async, between edges) → all outputs 0 immediately, state IDLE; start after release → full run completes correctly.
- Stuck-at fault: resp tied 0 with and2 truth → err_count=1, first_fail=3; resp tied X in sim → err_count=4, first_fail=0.
